// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller-port serialiser.
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } snes_state_t;

  localparam int          SNES_FRAME_BITS = 16;
  localparam logic [3:0]  SNES_ID_BITS    = 4'b1111;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // DATA is active-low; A/X/L/R are never pressed on this pad.
  function automatic logic [SNES_FRAME_BITS-1:0] snes_load_word(input logic [7:0] buttons);
    return {SNES_ID_BITS, 4'b1111, ~buttons};
  endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-flop synchroniser for an asynchronous console pin, with a registered
// level and a one-cycle rising-edge pulse aligned to that level.
module snes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   level_reg;
  logic                   rise_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_reg  <= '0;
      level_reg <= 1'b0;
      rise_reg  <= 1'b0;
    end else begin
      sync_reg  <= {sync_reg[SYNC_STAGES-2:0], async_in};
      level_reg <= sync_reg[SYNC_STAGES-1];
      rise_reg  <= sync_reg[SYNC_STAGES-1] & ~level_reg;
    end
  end

  assign level = level_reg;
  assign rise  = rise_reg;

endmodule

// File: rtl/snes_serial_out.sv
// Emulates a standard SNES pad: latch the button vector, shift it out on DATA.
// Optional link watchdog enabled by defining SNES_LINK_WATCHDOG_EN.
module snes_serial_out
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] buttons,
  input  logic       snes_latch,
  input  logic       snes_clk,
  output logic       snes_data,
  output logic       frame_done,
  output logic       link_ok
);

  logic latch_level;
  logic latch_rise;
  logic unused_clk_level;
  logic clk_rise;

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (snes_latch),
    .level    (latch_level),
    .rise     (latch_rise)
  );

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (snes_clk),
    .level    (unused_clk_level),
    .rise     (clk_rise)
  );

  snes_state_t                state_reg, state_next;
  logic [SNES_FRAME_BITS-1:0] sr_reg, sr_next;
  logic [4:0]                 cnt_reg, cnt_next;
  logic                       frame_done_reg, frame_done_next;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      sr_reg         <= '1;
      cnt_reg        <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sr_reg         <= sr_next;
      cnt_reg        <= cnt_next;
      frame_done_reg <= frame_done_next;
    end
  end

  // Latch has priority over everything, including a CLK edge in the same cycle.
  always_comb begin
    state_next      = state_reg;
    sr_next         = sr_reg;
    cnt_next        = cnt_reg;
    frame_done_next = 1'b0;
    if (latch_level) begin
      state_next = LOAD;
      sr_next    = snes_load_word(buttons);
      cnt_next   = '0;
    end else begin
      unique case (state_reg)
        LOAD:  state_next = SHIFT;
        SHIFT: begin
          if (clk_rise) begin
            sr_next  = {1'b0, sr_reg[SNES_FRAME_BITS-1:1]};
            cnt_next = cnt_reg + 5'd1;
            if (cnt_next == 5'(SNES_FRAME_BITS)) begin
              state_next      = DONE;
              frame_done_next = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign snes_data  = sr_reg[0];
  assign frame_done = frame_done_reg;

`ifdef SNES_LINK_WATCHDOG_EN
  localparam logic [20:0] WD_LIMIT = 21'(TIMEOUT_CYCLES);

  logic [20:0] wd_cnt_reg;
  logic        seen_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wd_cnt_reg <= '0;
      seen_reg   <= 1'b0;
    end else if (latch_rise) begin
      wd_cnt_reg <= '0;
      seen_reg   <= 1'b1;
    end else if (wd_cnt_reg < WD_LIMIT) begin
      wd_cnt_reg <= wd_cnt_reg + 21'd1;
    end
  end

  assign link_ok = seen_reg && (wd_cnt_reg < WD_LIMIT);
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_latch_rise;
  assign unused_latch_rise = latch_rise;
  assign link_ok = 1'b1;
`endif

endmodule

// File: tb/tb_snes_serial_out.sv
// Scoreboard bench: a console model pushes expected DATA bits per CLK edge,
// a monitor pops and compares them on each console CLK rising edge.
module tb_snes_serial_out;

  localparam int TMO = 1000;
`ifdef SNES_LINK_WATCHDOG_EN
  localparam logic EXP_LINK_RST = 1'b0;
`else
  localparam logic EXP_LINK_RST = 1'b1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] buttons;
  logic       snes_latch;
  logic       snes_clk;
  logic       snes_data;
  logic       frame_done;
  logic       link_ok;

  always #10 clk = ~clk;

  snes_serial_out #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .buttons    (buttons),
    .snes_latch (snes_latch),
    .snes_clk   (snes_clk),
    .snes_data  (snes_data),
    .frame_done (frame_done),
    .link_ok    (link_ok)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int done_cnt = 0;
  int exp_done = 0;
  int frame_no = 0;

  // Console/pad reference: current frame contents and edges consumed so far.
  logic [15:0] frame_bits;
  int          edge_k;
  bit          in_frame;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_frame(input logic [7:0] b);
    frame_bits = {8'hFF, ~b};
    edge_k     = 0;
    in_frame   = 1'b1;
  endtask

  task automatic do_latch(input logic [7:0] b, input int hold);
    buttons    = b;
    snes_latch = 1'b1;
    wait_cyc(hold);
    snes_latch = 1'b0;
    start_frame(b);
    wait_cyc(6);
    buttons = 8'($urandom);
  endtask

  task automatic clk_pulse();
    int e;
    snes_clk = 1'b0;
    wait_cyc(6);
    if (!in_frame)      e = 1;
    else if (edge_k < 16) e = int'(frame_bits[edge_k]);
    else                e = 0;
    exp_q.push_back(e);
    if (in_frame) begin
      edge_k++;
      if (edge_k == 16) exp_done++;
    end
    snes_clk = 1'b1;
    wait_cyc(6);
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) clk_pulse();
  endtask

  task automatic run_frame(input logic [7:0] b, input int n);
    do_latch(b, int'($urandom_range(2, 8)));
    pulses(n);
    wait_cyc(4);
    frame_no++;
    $display("frame %0d: buttons=%02h edges=%0d frame_done_count=%0d", frame_no, b, n, done_cnt);
    check("frame_done_count", done_cnt, exp_done);
  endtask

  always @(negedge clk) begin
    if (frame_done) done_cnt <= done_cnt + 1;
  end

  // Monitor: the console samples DATA on each CLK rising edge.
  initial begin
    int e;
    @(posedge reset_n);
    forever begin
      @(posedge snes_clk);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL data_queue: got edge with no expectation, required queued entry");
      end else begin
        e = exp_q.pop_front();
        if (e >= 0) check("snes_data", {31'd0, snes_data}, e);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int n;
    reset_n    = 1'b0;
    snes_latch = 1'b0;
    snes_clk   = 1'b1;
    buttons    = 8'h00;
    in_frame   = 1'b0;
    edge_k     = 0;
    frame_bits = '1;
    wait_cyc(5);
    check("reset_data", {31'd0, snes_data}, 1);
    check("reset_frame_done", {31'd0, frame_done}, 0);
    check("reset_link_ok", {31'd0, link_ok}, {31'd0, EXP_LINK_RST});
    reset_n = 1'b1;
    wait_cyc(10);
    check("idle_data", {31'd0, snes_data}, 1);
    check("idle_link_ok", {31'd0, link_ok}, {31'd0, EXP_LINK_RST});

    // B and Right pressed, with a 17th edge.
    run_frame(8'b1000_0001, 17);
    check("link_after_latch", {31'd0, link_ok}, 1);
    check("done_data_low", {31'd0, snes_data}, 0);

    // Sample freeze: buttons go to FF mid-shift.
    do_latch(8'h00, 6);
    buttons = 8'hFF;
    pulses(16);
    wait_cyc(4);
    check("freeze_done_count", done_cnt, exp_done);

    // Re-latch mid-frame after 5 edges.
    do_latch(8'($urandom), 4);
    pulses(5);
    run_frame(8'h08, 16);

    // Latch and CLK rising edges arriving in the same cycle.
    do_latch(8'($urandom), 4);
    pulses(7);
    b = 8'($urandom);
    snes_clk = 1'b0;
    wait_cyc(6);
    exp_q.push_back(-1);
    buttons    = b;
    snes_clk   = 1'b1;
    snes_latch = 1'b1;
    wait_cyc(1);
    snes_latch = 1'b0;
    start_frame(b);
    wait_cyc(6);
    buttons = 8'($urandom);
    pulses(16);
    wait_cyc(4);
    $display("collision frame: buttons=%02h frame_done_count=%0d", b, done_cnt);
    check("collision_done_count", done_cnt, exp_done);

    // Reset mid-frame.
    do_latch(8'($urandom), 3);
    pulses(6);
    reset_n = 1'b0;
    wait_cyc(2);
    in_frame = 1'b0;
    check("midreset_data", {31'd0, snes_data}, 1);
    check("midreset_frame_done", {31'd0, frame_done}, 0);
    check("midreset_link_ok", {31'd0, link_ok}, {31'd0, EXP_LINK_RST});
    reset_n = 1'b1;
    wait_cyc(6);
    pulses(3);
    wait_cyc(4);
    check("midreset_done_count", done_cnt, exp_done);

    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 18));
      run_frame(b, n);
    end

    // Link watchdog.
    wait_cyc(TMO + 20);
`ifdef SNES_LINK_WATCHDOG_EN
    check("link_timeout", {31'd0, link_ok}, 0);
`else
    check("link_timeout", {31'd0, link_ok}, 1);
`endif
    run_frame(8'($urandom), 16);
    check("link_restored", {31'd0, link_ok}, 1);

    wait_cyc(5);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
